// File: rtl/add_seq_pkg.sv
// Shared types for the chunked sequential adder.
// State encodings and the counter-width helper.
package add_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational CHUNK-bit ripple-carry slice.
// Full-adder cells chained LSB to MSB; holds no state.
module add_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  // ripple the carry through each bit position
  always_comb begin
    logic cy;
    s  = '0;
    cy = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/chunk_add_seq.sv
// Multi-cycle adder: one CHUNK slice per clock, LSB chunk first.
// Define ADD_SEQ_SUB_EN to add the sub port (a-b via inverted b).
module chunk_add_seq
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad
    $error("chunk_add_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [CHUNK-1:0] sl_s;
  logic             sl_c;

  add_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_sh_q[CHUNK-1:0]),
    .b    (b_sh_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_c)
  );

  // in_ready is gated by reset so every output reads 0 while held
  assign in_ready  = (state_q == ST_IDLE) & rst_n;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // next-state: capture, chunk shifting and result handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
`ifdef ADD_SEQ_SUB_EN
          if (sub) begin
            b_sh_d  = ~b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = WIDTH'({sl_s, sum_q} >> CHUNK);
        carry_d = sl_c;
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = sl_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // all state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_chunk_add_seq.sv
// Randomized self-checking bench for chunk_add_seq.
// Reference is plain (WIDTH+1)-bit arithmetic on a and b.
module tb_chunk_add_seq;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NC = W / C;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total;
  int bad;
  int nops;
  int nout;

  chunk_add_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) nout <= nout + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // one full transaction: wait ready, accept, time latency, hold, release
  task automatic do_op(input string tag,
                       input logic [W-1:0] ta,
                       input logic [W-1:0] tb_,
                       input logic ts,
                       input int gap,
                       input int hold);
    logic [W:0] exp;
    int n;
    int lat;
    exp = ref_add(ta, tb_, ts);
    repeat (gap) @(negedge clk);
    a = ta;
    b = tb_;
    sub = ts;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    in_valid = 1'($urandom);
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    out_ready = 1'($urandom);
    check({tag, "_busy"}, 32'({busy, in_ready}), 32'b10);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
      in_valid = 1'($urandom);
      a = W'($urandom);
      out_ready = 1'($urandom);
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(NC + 1));
    check({tag, "_res"}, 32'({cout, sum}), 32'(exp));
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"},
            32'({out_valid, in_ready, cout, sum}),
            32'({2'b10, exp}));
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    nops++;
    @(negedge clk);
    check({tag, "_rel"},
          32'({out_valid, busy, in_ready}), 32'b001);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;
    total = 0;
    bad = 0;
    nops = 0;
    nout = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    #1;
    check("rst", 32'({out_valid, busy, in_ready, cout, sum}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel", 32'({in_ready, busy, out_valid}), 32'b100);

    do_op("t1", 16'h00FF, 16'h0001, 1'b0, 1, 0);
    do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 0, 1);
    do_op("t3", 16'h1234, 16'h4321, 1'b0, 2, 6);

    // abort after two RUN edges
    @(negedge clk);
    a = 16'hAAAA;
    b = 16'h5555;
    sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_abort",
          32'({out_valid, busy, in_ready, cout, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t4_idle", 32'({in_ready, busy}), 32'b10);
    do_op("t4_next", 16'h0003, 16'h0004, 1'b0, 1, 1);

`ifdef ADD_SEQ_SUB_EN
    do_op("t5_neg", 16'h0005, 16'h0007, 1'b1, 0, 0);
    do_op("t5_pos", 16'h0007, 16'h0005, 1'b1, 0, 0);
`endif

    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (k < 8) rb = ~ra + W'(k & 1);
`ifdef ADD_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op("rnd", ra, rb, rs, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    check("count", 32'(nout), 32'(nops));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
